// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for the up/down counter FSM: steers its direction input so the
// counter ramps 0..MAX..0 a programmed number of times, tracking and checking it.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 2,
  parameter int SWEEPS  = 3,
  parameter bit CHECK_Z = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             z,
  output logic             x,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sweep_cnt,
  output logic             err
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [7:0]       SWEEPS_L = 8'(SWEEPS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_UP    = 2'd2,
    ST_DOWN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_x;
  logic             w_x_nxt;
  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] w_pos_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       w_cnt_inc;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_z_exp;

  // The shadow steps with the direction the counter saw this cycle, in every state.
  assign w_pos_nxt = r_x ? (r_pos - ONE) : (r_pos + ONE);
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_z_exp   = (r_pos == ZERO) || (r_pos == MAX);

  // Next-state, direction, completion and sweep-count logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = 1'b1;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cnt_nxt = 8'd0;
          if (w_pos_nxt == ZERO) begin
            w_state_nxt = ST_UP;
            w_x_nxt     = 1'b0;
          end else begin
            w_state_nxt = ST_ALIGN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pos_nxt == ZERO) begin
          w_state_nxt = ST_UP;
          w_x_nxt     = 1'b0;
        end else begin
          w_state_nxt = ST_ALIGN;
        end
      end
      ST_UP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pos_nxt == MAX) begin
          w_state_nxt = ST_DOWN;
        end else begin
          w_x_nxt = 1'b0;
        end
      end
      ST_DOWN: begin
        // abort outranks a completion landing on the same edge
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pos_nxt == ZERO) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == SWEEPS_L) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_UP;
            w_x_nxt     = 1'b0;
          end
        end else begin
          w_state_nxt = ST_DOWN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sticky terminal-count consistency check, only while a sequence runs.
  always_comb begin
    w_err_nxt = r_err;
    if (CHECK_Z && r_busy && (z != w_z_exp)) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_x     <= 1'b1;
      r_pos   <= ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_pos   <= w_pos_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign x         = r_x;
  assign pos       = r_pos;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sweep_cnt = r_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomised scoreboard bench for updown_sweep_ctrl, with a behavioural counter and
// a trajectory-based reference model (align ramp followed by a triangle wave).
module tb_updown_sweep_ctrl;

  localparam int W    = 2;
  localparam int MAXV = (1 << W) - 1;
  localparam int SW   = 3;
  localparam int PER  = 2 * MAXV;

  logic         clock;
  logic         reset;
  logic         start;
  logic         abort;
  logic         z;
  logic         x;
  logic [W-1:0] pos;
  logic         busy;
  logic         done;
  logic [7:0]   sweep_cnt;
  logic         err;

  updown_sweep_ctrl #(.WIDTH(W), .SWEEPS(SW), .CHECK_Z(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .z(z),
    .x(x), .pos(pos), .busy(busy), .done(done), .sweep_cnt(sweep_cnt), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural counter FSM; force_z suppresses z at MAX to provoke the error flag.
  logic [W-1:0] c_cnt;
  logic         force_z;
  always @(posedge clock or negedge reset) begin
    if (!reset) c_cnt <= W'(0);
    else if (x) c_cnt <= c_cnt - W'(1);
    else c_cnt <= c_cnt + W'(1);
  end
  assign z = ((c_cnt == W'(0)) || (c_cnt == W'(MAXV))) && !(force_z && (c_cnt == W'(MAXV)));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state
  int m_pos = 0, m_p = 0, m_t = 0, m_cnt = 0, m_edge = 0;
  bit m_busy = 0, m_x = 1, m_done = 0, m_err = 0;
  int sb[$];

  function automatic int align_of(int p);
    return (p == 0) ? (MAXV + 1) : p;
  endfunction

  function automatic int total_of(int p);
    return align_of(p) + SW * PER;
  endfunction

  // Position t edges after a start accepted at position p.
  function automatic int traj(int p, int t);
    int al, u;
    al = align_of(p);
    if (t <= al) return (p - t) & MAXV;
    u = (t - al) % PER;
    return (u <= MAXV) ? u : (PER - u);
  endfunction

  function automatic bit dir_of(int p, int t);
    return traj(p, t + 1) == ((traj(p, t) - 1) & MAXV);
  endfunction

  function automatic int sweeps_of(int p, int t);
    int al;
    al = align_of(p);
    return (t < al) ? 0 : (t - al) / PER;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_x = 1; m_busy = 0; m_done = 0; m_cnt = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic zs);
    if (m_busy && (zs != ((m_pos == 0) || (m_pos == MAXV)))) m_err = 1;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_p = m_pos; m_t = 1; m_busy = 1; m_cnt = 0;
        m_pos = traj(m_p, 1);
        m_x = dir_of(m_p, 1);
        sb.push_back(m_edge - 1 + total_of(m_p));
      end else begin
        m_pos = (m_pos - 1) & MAXV;
        m_x = 1;
      end
    end else if (abort) begin
      m_pos = traj(m_p, m_t + 1);
      m_busy = 0; m_x = 1;
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end else begin
      m_t++;
      m_pos = traj(m_p, m_t);
      m_cnt = sweeps_of(m_p, m_t);
      if (m_t == total_of(m_p)) begin
        m_busy = 0; m_done = 1; m_x = 1;
      end else begin
        m_x = dir_of(m_p, m_t);
      end
    end
  endtask

  task automatic tick();
    logic zs;
    zs = z;
    @(posedge clock);
    m_edge++;
    if (!reset) model_reset();
    else model_step(zs);
    #2;
  endtask

  task automatic expire(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic run_to_idle(input string name);
    for (int i = 0; i < 80 && m_busy; i++) tick();
    if (m_busy) expire(name);
  endtask

  // Monitor: compares every cycle and retires scoreboard entries on done pulses.
  int n_neg = 0;
  initial begin
    logic [W+12:0] act, exp;
    int e;
    forever begin
      @(negedge clock);
      n_neg++;
      act = {pos, x, busy, done, sweep_cnt, err};
      exp = {W'(m_pos), m_x, m_busy, m_done, 8'(m_cnt), m_err};
      chk("outputs{pos,x,busy,done,cnt,err}", 64'(act), 64'(exp));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(n_neg), 64'(e));
          chk("done_pos_cnt", 64'({pos, sweep_cnt}), 64'({W'(0), 8'(SW)}));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; force_z = 1'b0;
    tick(); tick();
    reset = 1'b1;
    repeat (8) tick();

    // Start in the cycle where pos=2.
    for (int i = 0; i < 8 && m_pos != 2; i++) tick();
    if (m_pos != 2) expire("wait_pos2");
    start = 1'b1; tick(); start = 1'b0;
    run_to_idle("seq_basic");
    repeat (3) tick();

    // Abort while ramping up through pos=2.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30 && !(m_busy && m_x && m_pos == 2 && m_t > align_of(m_p)) && !(m_busy && !m_x && m_pos == 2); i++) tick();
    if (!(m_busy && !m_x && m_pos == 2)) expire("wait_up2");
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (4) tick();

    // start re-pulsed while busy is ignored.
    start = 1'b1; tick();
    for (int i = 0; i < 80 && m_busy; i++) begin
      start = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    if (m_busy) expire("seq_repulse");
    repeat (2) tick();

    // z suppressed at MAX: err sets and stays through idle.
    force_z = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    run_to_idle("seq_forcez");
    force_z = 1'b0;
    repeat (8) tick();

    // Reset mid-DOWN with two sweeps complete, then a full fresh sequence.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 80 && !(m_busy && m_cnt == 2 && m_x && m_pos != 0 && m_pos != MAXV && m_t > align_of(m_p)); i++) tick();
    if (!(m_busy && m_cnt == 2)) expire("wait_down2");
    reset = 1'b0; model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    run_to_idle("seq_after_reset");

    // Random start/abort traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 29) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    run_to_idle("seq_random");
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives the direction input `x` of the team's free-running up/down counter FSM.
- Makes the counter perform a programmed number of full ramp sweeps: 0 up to MAX, then back down to 0.
- Keeps a shadow copy of the counter position, so reversals land exactly on the endpoints.
- Checks the counter's terminal output `z` against the shadow position and flags mismatches.

Parameters:
- WIDTH, 2, counter width in bits; MAX = 2^WIDTH-1.
- SWEEPS, 3, number of full up/down sweeps per start command (1..255).
- CHECK_Z, 1, when 1 the `z` consistency check drives `err`; when 0 `err` is tied low.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep sequence; sampled only in IDLE.
- abort  in  1  terminate the sequence; return to IDLE.
- z  in  1  terminal-count output from the counter FSM.
- x  out  1  direction to the counter FSM: 1 = count down, 0 = count up.
- pos  out  WIDTH  shadow counter position.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final sweep completes.
- sweep_cnt  out  8  completed sweeps in the current or last sequence.
- err  out  1  sticky `z` mismatch flag.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-sequence): state=IDLE, x=1, pos=0, busy=0, done=0, sweep_cnt=0, err=0.
- Counter contract: the counter resets to 0 and steps every clock, -1 when x=1 and +1 when x=0, modulo 2^WIDTH. It asserts z exactly when its state is 0 or MAX.
- Shadow position: every edge, pos <= pos-1 if x=1, else pos+1, mod 2^WIDTH. This holds in all states, including IDLE.
- All outputs are registered. pos_n is the value pos takes at the current edge.
- States: IDLE, ALIGN, UP, DOWN.
- IDLE:
  - x=1.
  - start=1 -> ALIGN; sweep_cnt cleared to 0.
  - If pos_n==0 on the same edge, go directly to UP.
- ALIGN:
  - x=1, descending.
  - On the edge where pos_n==0: -> UP, x<=0.
  - If pos==0 when ALIGN is entered, it wraps to MAX and descends again.
- UP:
  - x=0.
  - On the edge where pos_n==MAX: -> DOWN, x<=1. MAX is therefore held for exactly one cycle.
- DOWN:
  - x=1.
  - On the edge where pos_n==0: sweep_cnt<=sweep_cnt+1.
  - If the incremented value == SWEEPS: -> IDLE, done<=1 for one cycle, x stays 1.
  - Otherwise: -> UP, x<=0.
- Sweep period: 2*MAX cycles (6 for WIDTH=2).
- Start to done latency = (cycles to reach 0 in ALIGN) + SWEEPS*2*MAX.
- start while busy: ignored.
- abort=1 in a non-IDLE state:
  - -> IDLE at next edge; x<=1; no done pulse; sweep_cnt holds its value.
  - abort wins over a sweep completion on the same edge.
  - abort in IDLE: no effect.
- start and abort both high in IDLE: abort ignored, start accepted.
- err, when CHECK_Z=1: set in any cycle with busy=1 where z != (pos==0 || pos==MAX). Cleared only by reset. Not evaluated in IDLE.
- done is low in every cycle except the completion pulse.

Test Plan:
- Reset release, start held low for 8 cycles -> pos cycles 0,3,2,1,0,3,2,1; x=1; busy=0; done=0.
- WIDTH=2, SWEEPS=3, start pulsed in the cycle where pos=2:
  - ALIGN 2 edges (pos 1,0), then pos sequence 1,2,3,2,1,0 repeated 3 times.
  - sweep_cnt steps 1,2,3; done pulses once with pos=0, 20 edges after start; busy drops on the same edge.
- abort asserted while in UP with pos=2 -> next edge state=IDLE, x=1, busy=0, no done, sweep_cnt unchanged.
- start re-pulsed during a sequence (busy=1) -> ignored; sequence and done timing identical to the unperturbed run.
- Counter model forces z=0 while pos=MAX in UP -> err=1 from that cycle and stays 1 through the remaining sweeps and IDLE, until reset.
- reset asserted mid-DOWN with sweep_cnt=2 -> immediately x=1, pos=0, busy=0, sweep_cnt=0, err=0; a new start after release runs a full 3-sweep sequence.
